// File: rtl/voice_allocator.sv
// voice_allocator: polyphony scheduler that maps note events onto oscillator slots.
// Ports: clk/rst, note_* event handshake in, voice_done in, per-voice state/key/vel/trigger out, steal pulse.
module voice_allocator #(
  parameter int N_VOICES = 8,
  parameter int KEY_W    = 7,
  parameter int VEL_W    = 7,
  parameter int AGE_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      note_valid,
  output logic                      note_ready,
  input  logic                      note_on,
  input  logic [KEY_W-1:0]          note_key,
  input  logic [VEL_W-1:0]          note_velocity,
  input  logic [N_VOICES-1:0]       voice_done,
  output logic [N_VOICES-1:0]       voice_active,
  output logic [N_VOICES-1:0]       voice_gate,
  output logic [N_VOICES-1:0]       voice_trigger,
  output logic [N_VOICES*KEY_W-1:0] voice_key,
  output logic [N_VOICES*VEL_W-1:0] voice_velocity,
  output logic                      steal
);

  localparam int IW = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};
  localparam logic [IW-1:0] LAST = IW'(N_VOICES - 1);

  logic [1:0]        fsm;
  logic [IW-1:0]     idx;
  logic              ev_on;
  logic [KEY_W-1:0]  ev_key;
  logic [VEL_W-1:0]  ev_vel;

  logic              m_hit, f_hit, o_hit;
  logic [IW-1:0]     m_idx, f_idx, o_idx;
  logic [AGE_W-1:0]  o_age;

  logic [N_VOICES-1:0] act, gate, trig;
  logic [KEY_W-1:0]    key_r [N_VOICES];
  logic [VEL_W-1:0]    vel_r [N_VOICES];
  logic [AGE_W-1:0]    age   [N_VOICES];

  logic              v_act, v_gate, key_hit;
  logic [AGE_W-1:0]  v_age;
  logic [IW-1:0]     c_idx;
  logic              c_do, c_steal;

  // Voice under inspection this SCAN cycle.
  // Note-on matches any sounding voice, note-off only held ones.
  always_comb begin
    v_act   = act[idx];
    v_gate  = gate[idx];
    v_age   = age[idx];
    key_hit = (key_r[idx] == ev_key) && (ev_on ? v_act : v_gate);
  end

  always_comb begin
    c_idx   = o_idx;
    c_do    = 1'b0;
    c_steal = 1'b0;
    if (ev_on) begin
      c_do = 1'b1;
      priority case (1'b1)
        m_hit:   c_idx = m_idx;
        f_hit:   c_idx = f_idx;
        default: begin
          c_idx   = o_idx;
          c_steal = 1'b1;
        end
      endcase
    end else begin
      c_idx = m_idx;
      c_do  = m_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm    <= S_IDLE;
      idx    <= '0;
      ev_on  <= 1'b0;
      ev_key <= '0;
      ev_vel <= '0;
      m_hit  <= 1'b0;
      f_hit  <= 1'b0;
      o_hit  <= 1'b0;
      m_idx  <= '0;
      f_idx  <= '0;
      o_idx  <= '0;
      o_age  <= '0;
      act    <= '0;
      gate   <= '0;
      trig   <= '0;
      steal  <= 1'b0;
      for (int i = 0; i < N_VOICES; i++) begin
        key_r[i] <= '0;
        vel_r[i] <= '0;
        age[i]   <= '0;
      end
    end else begin
      trig  <= '0;
      steal <= 1'b0;
      for (int i = 0; i < N_VOICES; i++)
        if (act[i] && !gate[i] && voice_done[i])
          act[i] <= 1'b0;
      case (fsm)
        S_IDLE: begin
          if (note_valid) begin
            ev_on  <= note_on;
            ev_key <= note_key;
            ev_vel <= note_velocity;
            idx    <= '0;
            m_hit  <= 1'b0;
            f_hit  <= 1'b0;
            o_hit  <= 1'b0;
            fsm    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (key_hit && !m_hit) begin
            m_hit <= 1'b1;
            m_idx <= idx;
          end
          if (!v_act && !f_hit) begin
            f_hit <= 1'b1;
            f_idx <= idx;
          end
          if (v_act && (!o_hit || v_age > o_age)) begin
            o_hit <= 1'b1;
            o_idx <= idx;
            o_age <= v_age;
          end
          if (idx == LAST) fsm <= S_COMMIT;
          else             idx <= idx + 1'b1;
        end
        S_COMMIT: begin
          fsm <= S_IDLE;
          // Placed after the voice_done loop so a commit wins.
          if (c_do && ev_on) begin
            steal <= c_steal;
            for (int i = 0; i < N_VOICES; i++) begin
              if (c_idx == IW'(i)) begin
                act[i]   <= 1'b1;
                gate[i]  <= 1'b1;
                trig[i]  <= 1'b1;
                key_r[i] <= ev_key;
                vel_r[i] <= ev_vel;
                age[i]   <= '0;
              end else if (act[i] && age[i] != AGE_MAX) begin
                age[i] <= age[i] + 1'b1;
              end
            end
          end else if (c_do) begin
            gate[c_idx] <= 1'b0;
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  assign note_ready    = (fsm == S_IDLE);
  assign voice_active  = act;
  assign voice_gate    = gate;
  assign voice_trigger = trig;

  for (genvar g = 0; g < N_VOICES; g++) begin : g_pack
    assign voice_key[g*KEY_W +: KEY_W]      = key_r[g];
    assign voice_velocity[g*VEL_W +: VEL_W] = vel_r[g];
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: table vectors, directed corner sequences and
// randomized events checked against a behavioural voice model.
module tb_voice_allocator;

  localparam int N  = 8;
  localparam int KW = 7;
  localparam int VW = 7;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          note_valid;
  logic          note_ready;
  logic          note_on;
  logic [KW-1:0] note_key;
  logic [VW-1:0] note_velocity;
  logic [N-1:0]  voice_done;
  logic [N-1:0]  voice_active;
  logic [N-1:0]  voice_gate;
  logic [N-1:0]  voice_trigger;
  logic [N*KW-1:0] voice_key;
  logic [N*VW-1:0] voice_velocity;
  logic          steal;

  always #5 clk = ~clk;

  voice_allocator #(
    .N_VOICES(N), .KEY_W(KW), .VEL_W(VW), .AGE_W(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .note_valid(note_valid), .note_ready(note_ready),
    .note_on(note_on), .note_key(note_key),
    .note_velocity(note_velocity), .voice_done(voice_done),
    .voice_active(voice_active), .voice_gate(voice_gate),
    .voice_trigger(voice_trigger), .voice_key(voice_key),
    .voice_velocity(voice_velocity), .steal(steal)
  );

  int total = 0;
  int bad   = 0;

  // model: 0 free, 1 held, 2 releasing
  int m_state [N];
  int m_key   [N];
  int m_vel   [N];
  int m_age   [N];
  logic [N-1:0] exp_trig;
  bit exp_steal;

  typedef struct {
    bit rst_b;
    bit on;
    int key;
    int vel;
    int tidx;
    bit st;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i] = 0; m_key[i] = 0; m_vel[i] = 0; m_age[i] = 0;
    end
    exp_trig  = '0;
    exp_steal = 1'b0;
  endfunction

  function automatic int m_note(bit on, int key, int vel);
    int idx;
    int best;
    idx = -1;
    best = -1;
    exp_trig  = '0;
    exp_steal = 1'b0;
    if (on) begin
      for (int i = 0; i < N; i++)
        if (idx < 0 && m_state[i] != 0 && m_key[i] == key) idx = i;
      for (int i = 0; i < N; i++)
        if (idx < 0 && m_state[i] == 0) idx = i;
      if (idx < 0) begin
        for (int i = 0; i < N; i++)
          if (best < 0 || m_age[i] > m_age[best]) best = i;
        idx = best;
        exp_steal = 1'b1;
      end
      for (int i = 0; i < N; i++)
        if (i != idx && m_state[i] != 0 && m_age[i] < (1 << AW) - 1)
          m_age[i]++;
      m_state[idx] = 1;
      m_key[idx]   = key;
      m_vel[idx]   = vel;
      m_age[idx]   = 0;
      exp_trig[idx] = 1'b1;
    end else begin
      for (int i = 0; i < N; i++)
        if (idx < 0 && m_state[i] == 1 && m_key[i] == key) idx = i;
      if (idx >= 0) m_state[idx] = 2;
    end
    return idx;
  endfunction

  function automatic void m_free(logic [N-1:0] mask);
    for (int i = 0; i < N; i++)
      if (mask[i] && m_state[i] == 2) m_state[i] = 0;
  endfunction

  task automatic check_all(input string tag);
    logic [N-1:0]    a, g;
    logic [N*KW-1:0] k;
    logic [N*VW-1:0] v;
    int kk, vv;
    for (int i = 0; i < N; i++) begin
      kk = m_key[i];
      vv = m_vel[i];
      a[i] = (m_state[i] != 0);
      g[i] = (m_state[i] == 1);
      k[i*KW +: KW] = kk[KW-1:0];
      v[i*VW +: VW] = vv[VW-1:0];
    end
    chk({tag, ".active"}, 64'(voice_active), 64'(a));
    chk({tag, ".gate"}, 64'(voice_gate), 64'(g));
    chk({tag, ".key"}, 64'(voice_key), 64'(k));
    chk({tag, ".vel"}, 64'(voice_velocity), 64'(v));
    chk({tag, ".trig"}, 64'(voice_trigger), 64'(exp_trig));
    chk({tag, ".steal"}, 64'(steal), 64'(exp_steal));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    note_valid = 1'b0;
    note_on = 1'b0;
    note_key = '0;
    note_velocity = '0;
    voice_done = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_reset();
    @(negedge clk);
  endtask

  task automatic accept(input bit on, input int key, input int vel);
    int w;
    @(negedge clk);
    note_valid = 1'b1;
    note_on = on;
    note_key = KW'(key);
    note_velocity = VW'(vel);
    w = 0;
    while (!note_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (w >= 40) begin
      total++; bad++;
      $display("FAIL accept_timeout got=busy want=ready");
    end
    @(posedge clk);
    #1 note_valid = 1'b0;
  endtask

  task automatic send(input bit on, input int key, input int vel,
                      input logic [N-1:0] mask, input int dc,
                      output int lowcnt);
    int k;
    accept(on, key, vel);
    k = 1;
    lowcnt = 0;
    forever begin
      @(negedge clk);
      voice_done = (k == dc) ? mask : '0;
      if (note_ready) break;
      if (k > 40) begin
        total++; bad++;
        $display("FAIL ready_timeout got=busy want=ready");
        break;
      end
      lowcnt++;
      k++;
    end
  endtask

  task automatic pulse_done(input logic [N-1:0] mask, input string tag);
    @(negedge clk);
    voice_done = mask;
    @(negedge clk);
    voice_done = '0;
    m_free(mask);
    exp_trig  = '0;
    exp_steal = 1'b0;
    check_all(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=hang want=finish");
    $fatal(1);
  end

  initial begin
    int lc;
    int idx;
    logic [N-1:0] want;
    logic [N-1:0] rmask;
    bit on;
    int key, vel;

    tbl.push_back('{1, 1, 69, 100, 0, 0});
    tbl.push_back('{1, 1, 60, 10, 0, 0});
    for (int i = 1; i < 8; i++)
      tbl.push_back('{0, 1, 60 + i, 10 + i, i, 0});
    tbl.push_back('{0, 1, 72, 33, 0, 1});
    tbl.push_back('{0, 1, 61, 44, 1, 0});
    tbl.push_back('{0, 0, 65, 0, -1, 0});
    tbl.push_back('{0, 1, 80, 55, 2, 1});
    tbl.push_back('{1, 1, 64, 20, 0, 0});
    tbl.push_back('{0, 1, 64, 50, 0, 0});

    for (int t = 0; t < tbl.size(); t++) begin
      if (tbl[t].rst_b) begin
        do_reset();
        chk("rst.ready", 64'(note_ready), 64'd1);
        check_all("rst");
      end
      idx = m_note(tbl[t].on, tbl[t].key, tbl[t].vel);
      send(tbl[t].on, tbl[t].key, tbl[t].vel, '0, 0, lc);
      want = '0;
      if (tbl[t].tidx >= 0 && tbl[t].on) want[tbl[t].tidx] = 1'b1;
      chk("tbl.trig", 64'(voice_trigger), 64'(want));
      chk("tbl.steal", 64'(steal), 64'(tbl[t].st));
      if (tbl[t].tidx >= 0 && tbl[t].on)
        chk("tbl.key", 64'(voice_key[tbl[t].tidx*KW +: KW]),
            64'(tbl[t].key));
      if (!tbl[t].on)
        chk("tbl.off_gate", 64'(voice_gate[5]), 64'd0);
      check_all("tbl");
      if (t == 0) chk("tbl.ready_low", 64'(lc), 64'd9);
      @(negedge clk);
      chk("tbl.trig_1cyc", 64'(voice_trigger), 64'd0);
      chk("tbl.steal_1cyc", 64'(steal), 64'd0);
    end
    chk("retrig.v1_free", 64'(voice_active[1]), 64'd0);

    // note-off then release completion, then absent key
    do_reset();
    void'(m_note(1, 60, 70));
    send(1, 60, 70, '0, 0, lc);
    void'(m_note(0, 60, 0));
    send(0, 60, 0, '0, 0, lc);
    chk("off.gate0", 64'(voice_gate[0]), 64'd0);
    chk("off.act0", 64'(voice_active[0]), 64'd1);
    check_all("off");
    pulse_done(8'h01, "done");
    chk("done.act0", 64'(voice_active[0]), 64'd0);
    chk("done.key_kept", 64'(voice_key[KW-1:0]), 64'd60);
    void'(m_note(0, 61, 0));
    send(0, 61, 0, '0, 0, lc);
    check_all("off_absent");

    // done in the commit cycle that reallocates voice 3
    do_reset();
    for (int i = 0; i < 8; i++) begin
      void'(m_note(1, 60 + i, 30));
      send(1, 60 + i, 30, '0, 0, lc);
    end
    void'(m_note(0, 63, 0));
    send(0, 63, 0, '0, 0, lc);
    chk("c5.rel", 64'(voice_gate[3]), 64'd0);
    void'(m_note(1, 63, 90));
    send(1, 63, 90, 8'h08, 9, lc);
    m_free(8'h08);
    chk("c5.held_gate", 64'(voice_gate[3]), 64'd1);
    chk("c5.held_act", 64'(voice_active[3]), 64'd1);
    check_all("c5");
    pulse_done(8'h08, "c5_ign");

    // reset mid-scan drops the event
    do_reset();
    void'(m_note(1, 60, 1));
    send(1, 60, 1, '0, 0, lc);
    void'(m_note(1, 61, 2));
    send(1, 61, 2, '0, 0, lc);
    accept(1, 62, 5);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    check_all("midrst");
    chk("midrst.ready", 64'(note_ready), 64'd1);
    void'(m_note(1, 70, 9));
    send(1, 70, 9, '0, 0, lc);
    chk("midrst.v0", 64'(voice_trigger), 64'd1);
    check_all("midrst_post");

    // randomized events against the model
    do_reset();
    for (int r = 0; r < 60; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        rmask = N'($urandom);
        pulse_done(rmask, "rnd_done");
      end
      on  = ($urandom_range(0, 2) != 0);
      key = 60 + $urandom_range(0, 11);
      vel = $urandom_range(1, 127);
      void'(m_note(on, key, vel));
      send(on, key, vel, '0, 0, lc);
      check_all("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
